usb_tx_arbiter: RTL and testbench

Round-robin arbiter and framer sharing the single host-bound byte FIFO between up to NUM_CH on-chip data sources. Each granted channel's packet is wrapped as header, length, payload and XOR checksum, then pushed into the TX FIFO. The FTDI controller drains that FIFO toward the FT245-style bus. All logic runs in the clk_pll domain.

---
 rtl/usb_frame_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/usb_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_usb_tx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_frame_pkg.sv
// -----------------------------------------------------------------------------
// usb_frame_pkg
// Shared framing definitions for the host-bound USB byte stream. Each frame on
// the wire is: header (SYNC_HDR | channel), length, payload bytes, XOR checksum.
// The TX arbiter and the RX deframer both import this package so that the frame
// layout is defined in exactly one place.
// -----------------------------------------------------------------------------
package usb_frame_pkg;

  // Upper nibble of every header byte; the low nibble carries the channel.
  localparam logic [7:0] SYNC_HDR = 8'hA0;

  // Non-payload bytes per frame: header, length and checksum.
  localparam int FRAME_OVERHEAD_BYTES = 3;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LENGTH,
    PAYLOAD,
    CHECKSUM
  } frame_state_e;

  // Total bytes on the wire for a frame carrying len payload bytes.
  function automatic logic [8:0] frame_byte_count(input logic [7:0] len);
    return {1'b0, len} + 9'(FRAME_OVERHEAD_BYTES);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotate-priority picker. The search starts at ptr_i and wraps
// around, so the first requesting channel at or after the pointer wins.
//
// Ports:
//   req_i      [NUM_CH-1:0]  request vector, one bit per channel
//   ptr_i      [3:0]         round-robin pointer (must be < NUM_CH)
//   grant_o    [3:0]         index of the winning channel (0 when none)
//   any_req_o                at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [3:0]        ptr_i,
  output logic [3:0]        grant_o,
  output logic              any_req_o
);

  logic [NUM_CH-1:0] req_rot;
  logic [4:0]        idx_sum;

  // Rotating the doubled vector right by the pointer puts the pointer's
  // channel at bit 0, so a plain lowest-bit search gives pointer order.
  assign req_rot = NUM_CH'({req_i, req_i} >> ptr_i);

  // Scan from the highest offset down so the lowest set offset is the last
  // one written, then map the offset back to an absolute channel index.
  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    idx_sum   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        idx_sum   = {1'b0, ptr_i} + 5'(k);
        any_req_o = 1'b1;
      end
    end
    if (idx_sum >= 5'(NUM_CH)) begin
      idx_sum = idx_sum - 5'(NUM_CH);
    end
    grant_o = idx_sum[3:0];
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// usb_tx_arbiter
// Round-robin arbiter and framer that shares the host-bound TX byte FIFO among
// NUM_CH on-chip sources. A granted channel's packet is sent as header, length,
// payload and XOR checksum. Once granted, a frame always runs to completion.
//
// Ports:
//   clk_pll         system clock
//   reset_n         synchronous, active-low reset
//   ch_req          per-channel level request (complete packet ready)
//   ch_len          per-channel payload length, byte slice [8i+7:8i]
//   ch_data         per-channel first-word-fall-through payload byte
//   ch_pop          one-hot strobe: granted channel's byte consumed this cycle
//   fifo_data_out   byte presented to the TX FIFO
//   fifo_push_data  push strobe to the TX FIFO
//   fifo_full       TX FIFO cannot accept a byte this cycle
//   busy            a frame is in progress
//   grant_ch        channel currently or last granted
// -----------------------------------------------------------------------------
module usb_tx_arbiter
  import usb_frame_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int MAX_LEN = 255
) (
  input  logic                  clk_pll,
  input  logic                  reset_n,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [8*NUM_CH-1:0]   ch_len,
  input  logic [8*NUM_CH-1:0]   ch_data,
  output logic [NUM_CH-1:0]     ch_pop,
  output logic [7:0]            fifo_data_out,
  output logic                  fifo_push_data,
  input  logic                  fifo_full,
  output logic                  busy,
  output logic [3:0]            grant_ch
);

  frame_state_e state_q, state_d;
  logic [3:0]   ptr_q, ptr_d;
  logic [3:0]   grant_q, grant_d;
  logic [7:0]   len_q, len_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   csum_q, csum_d;

  logic [3:0]   arb_grant;
  logic         arb_any;
  logic [7:0]   sel_len;
  logic [7:0]   clamp_len;
  logic [7:0]   sel_data;
  logic [7:0]   out_byte;
  logic         emitting;
  logic         advance;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .req_i     (ch_req),
    .ptr_i     (ptr_q),
    .grant_o   (arb_grant),
    .any_req_o (arb_any)
  );

  // Channel slice muxes: the length of the prospective winner (used at grant)
  // and the payload byte of the channel already holding the grant.
  always_comb begin
    sel_len  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_grant == 4'(i)) sel_len = ch_len[8*i +: 8];
      if (grant_q == 4'(i))   sel_data = ch_data[8*i +: 8];
    end
    clamp_len = ({1'b0, sel_len} > 9'(MAX_LEN)) ? 8'(MAX_LEN) : sel_len;
  end

  // Byte on the FIFO bus for the current state; zero while idle.
  always_comb begin
    case (state_q)
      HEADER:   out_byte = SYNC_HDR | {4'h0, grant_q};
      LENGTH:   out_byte = len_q;
      PAYLOAD:  out_byte = sel_data;
      CHECKSUM: out_byte = csum_q;
      default:  out_byte = 8'h00;
    endcase
  end

  assign emitting       = (state_q != IDLE);
  assign advance        = emitting && !fifo_full;
  assign fifo_data_out  = out_byte;
  assign fifo_push_data = advance;
  assign busy           = emitting;
  assign grant_ch       = grant_q;

  // A payload byte is only consumed when it is actually pushed.
  always_comb begin
    ch_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_pop[i] = advance && (state_q == PAYLOAD) && (grant_q == 4'(i));
    end
  end

  // Framing FSM next-state. Every emitting state holds while the FIFO is full.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          ptr_d   = (arb_grant == 4'(NUM_CH - 1)) ? 4'd0 : arb_grant + 4'd1;
          len_d   = clamp_len;
          cnt_d   = clamp_len;
          csum_d  = 8'h00;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (advance) state_d = LENGTH;
      end
      LENGTH: begin
        if (advance) state_d = (len_q == 8'd0) ? CHECKSUM : PAYLOAD;
      end
      PAYLOAD: begin
        if (advance) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = CHECKSUM;
        end
      end
      CHECKSUM: begin
        if (advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (advance && (state_q != CHECKSUM)) begin
      csum_d = csum_q ^ out_byte;
    end
  end

  // State registers; reset abandons any partial frame and restarts the
  // round-robin search at channel 0.
  always_ff @(posedge clk_pll) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= 4'd0;
      grant_q <= 4'd0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      csum_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_arbiter
// Directed bench for usb_tx_arbiter (NUM_CH=4, MAX_LEN=16). A channel model
// feeds first-word-fall-through data and drops each request once it has been
// granted. Expected frame bytes and pop strobes are queued as stimulus is
// issued; an independent monitor pops and compares them whenever the DUT
// pushes a byte or pulses ch_pop.
// -----------------------------------------------------------------------------
module tb_usb_tx_arbiter;

  logic        clk_pll;
  logic        reset_n;
  logic [3:0]  ch_req;
  logic [31:0] ch_len;
  logic [31:0] ch_data;
  logic [3:0]  ch_pop;
  logic [7:0]  fifo_data_out;
  logic        fifo_push_data;
  logic        fifo_full;
  logic        busy;
  logic [3:0]  grant_ch;

  usb_tx_arbiter #(
    .NUM_CH  (4),
    .MAX_LEN (16)
  ) dut (
    .clk_pll        (clk_pll),
    .reset_n        (reset_n),
    .ch_req         (ch_req),
    .ch_len         (ch_len),
    .ch_data        (ch_data),
    .ch_pop         (ch_pop),
    .fifo_data_out  (fifo_data_out),
    .fifo_push_data (fifo_push_data),
    .fifo_full      (fifo_full),
    .busy           (busy),
    .grant_ch       (grant_ch)
  );

  initial clk_pll = 1'b0;
  always #5 clk_pll = ~clk_pll;

  typedef struct {
    logic [7:0] data;
    bit         hdr;
    int         gap;
  } expEntry;

  expEntry    expQ[$];
  int         popQ[$];
  int         nChecks = 0;
  int         nFail = 0;
  int         cyc = 0;
  int         lastHdrCyc = 0;
  int         pktCnt[4];
  int         idxCh[4];
  logic [7:0] lenCfg[4];
  logic       busyPrev;

  // Payload pattern of every channel: 0x11, 0x22, 0x33, ...
  function automatic logic [7:0] genByte(input int idx);
    return 8'((idx + 1) * 17);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive channel inputs from the channel model state.
  task automatic applyStimulus();
    for (int i = 0; i < 4; i++) begin
      ch_req[i]         = (pktCnt[i] != 0);
      ch_len[8*i +: 8]  = lenCfg[i];
      ch_data[8*i +: 8] = genByte(idxCh[i]);
    end
  endtask

  // One clock: sample pops mid-cycle, then after the edge advance each
  // channel's read pointer and retire the request of a newly granted channel.
  task automatic stepCycle();
    logic [3:0] popS;
    int g;
    @(negedge clk_pll);
    popS = ch_pop;
    @(posedge clk_pll);
    #1;
    for (int i = 0; i < 4; i++) if (popS[i]) idxCh[i]++;
    if (busy && !busyPrev) begin
      g = int'(grant_ch);
      if (g < 4) begin
        if (pktCnt[g] > 0) pktCnt[g]--;
        idxCh[g] = 0;
      end
    end
    busyPrev = busy;
    applyStimulus();
  endtask

  task automatic pushExp(input logic [7:0] d, input bit hdr, input int gap);
    expEntry e;
    e.data = d;
    e.hdr  = hdr;
    e.gap  = gap;
    expQ.push_back(e);
  endtask

  // Bench-side frame model: header, length, pattern payload, XOR checksum.
  task automatic expectFrame(input int ch, input int len, input int gap);
    logic [7:0] csum;
    logic [7:0] b;
    b = 8'hA0 | 8'(ch);
    pushExp(b, 1'b1, gap);
    csum = b;
    pushExp(8'(len), 1'b0, 0);
    csum = csum ^ 8'(len);
    for (int k = 0; k < len; k++) begin
      b = genByte(k);
      pushExp(b, 1'b0, 0);
      csum = csum ^ b;
      popQ.push_back(ch);
    end
    pushExp(csum, 1'b0, 0);
  endtask

  task automatic waitIdle(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (expQ.size() == 0 && popQ.size() == 0 && !busy &&
          pktCnt[0] == 0 && pktCnt[1] == 0 && pktCnt[2] == 0 && pktCnt[3] == 0) begin
        done = 1'b1;
        break;
      end
      stepCycle();
    end
    checkOutput({name, " drain"}, 32'(done), 32'd1);
  endtask

  task automatic waitPop(input int ch, input int target, input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (idxCh[ch] == target) begin
        done = 1'b1;
        break;
      end
      stepCycle();
    end
    checkOutput({name, " reach"}, 32'(done), 32'd1);
  endtask

  // Monitor: compare every pushed byte and every pop strobe to the queues,
  // and flag any push or pop while the FIFO is full.
  always @(negedge clk_pll) begin
    expEntry e;
    int      popCh;
    cyc++;
    if (fifo_full === 1'b1) begin
      checkOutput("stall quiet", {27'd0, fifo_push_data, ch_pop}, 32'd0);
    end
    if (fifo_push_data === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected push", {24'd0, fifo_data_out}, 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("push byte", {24'd0, fifo_data_out}, {24'd0, e.data});
        if (e.hdr) begin
          if (e.gap != 0) checkOutput("frame gap", 32'(cyc - lastHdrCyc), 32'(e.gap));
          lastHdrCyc = cyc;
        end
      end
    end
    if (ch_pop !== 4'b0000 && ch_pop !== 4'bxxxx) begin
      if (popQ.size() == 0) begin
        checkOutput("unexpected pop", {28'd0, ch_pop}, 32'd0);
      end else begin
        popCh = popQ.pop_front();
        checkOutput("ch_pop", {28'd0, ch_pop}, 32'd1 << popCh);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    fifo_full = 1'b0;
    busyPrev  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pktCnt[i] = 0;
      idxCh[i]  = 0;
      lenCfg[i] = 8'd0;
    end
    applyStimulus();
    repeat (3) stepCycle();

    // Reset state.
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset push", {31'd0, fifo_push_data}, 32'd0);
    checkOutput("reset ch_pop", {28'd0, ch_pop}, 32'd0);
    checkOutput("reset data", {24'd0, fifo_data_out}, 32'd0);
    checkOutput("reset grant", {28'd0, grant_ch}, 32'd0);
    reset_n = 1'b1;
    stepCycle();

    // Round robin: all channels requesting, len 1, ch0 has two packets.
    $display("[TB] round robin");
    for (int i = 0; i < 4; i++) lenCfg[i] = 8'd1;
    pktCnt[0] = 2; pktCnt[1] = 1; pktCnt[2] = 1; pktCnt[3] = 1;
    expectFrame(0, 1, 0);
    expectFrame(1, 1, 5);
    expectFrame(2, 1, 5);
    expectFrame(3, 1, 5);
    expectFrame(0, 1, 5);
    applyStimulus();
    waitIdle(200, "roundRobin");

    // Single frame on ch2; XOR of A2,03,11,22,33 is A1.
    $display("[TB] single frame");
    lenCfg[2] = 8'd3; pktCnt[2] = 1; idxCh[2] = 0;
    pushExp(8'hA2, 1'b1, 0);
    pushExp(8'h03, 1'b0, 0);
    pushExp(8'h11, 1'b0, 0);
    pushExp(8'h22, 1'b0, 0);
    pushExp(8'h33, 1'b0, 0);
    pushExp(8'hA1, 1'b0, 0);
    repeat (3) popQ.push_back(2);
    applyStimulus();
    waitIdle(100, "single");

    // Zero length on ch1, with the FIFO full during the checksum cycle.
    $display("[TB] zero length");
    lenCfg[1] = 8'd0; pktCnt[1] = 1; idxCh[1] = 0;
    pushExp(8'hA1, 1'b1, 0);
    pushExp(8'h00, 1'b0, 0);
    pushExp(8'hA1, 1'b0, 0);
    applyStimulus();
    stepCycle();
    checkOutput("zeroLen grant", {28'd0, grant_ch}, 32'd1);
    stepCycle();
    stepCycle();
    fifo_full = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("csum hold busy", {31'd0, busy}, 32'd1);
    fifo_full = 1'b0;
    waitIdle(100, "zeroLen");

    // Backpressure: FIFO full for 5 cycles starting at payload byte 2.
    $display("[TB] backpressure");
    lenCfg[2] = 8'd4; pktCnt[2] = 1; idxCh[2] = 0;
    expectFrame(2, 4, 0);
    applyStimulus();
    waitPop(2, 1, 50, "backpressure");
    fifo_full = 1'b1;
    repeat (5) stepCycle();
    checkOutput("stall busy", {31'd0, busy}, 32'd1);
    fifo_full = 1'b0;
    waitIdle(100, "backpressure");

    // Clamp: ch0 asks for 255 bytes, MAX_LEN is 16.
    $display("[TB] clamp");
    lenCfg[0] = 8'd255; pktCnt[0] = 1; idxCh[0] = 0;
    expectFrame(0, 16, 0);
    applyStimulus();
    waitIdle(200, "clamp");

    // Reset during payload byte 2 of an 8-byte ch2 frame.
    $display("[TB] reset mid-frame");
    lenCfg[2] = 8'd8; pktCnt[2] = 1; idxCh[2] = 0;
    pushExp(8'hA2, 1'b1, 0);
    pushExp(8'h08, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      pushExp(genByte(k), 1'b0, 0);
      popQ.push_back(2);
    end
    applyStimulus();
    waitPop(2, 2, 50, "midReset");
    reset_n = 1'b0;
    stepCycle();
    checkOutput("midReset busy", {31'd0, busy}, 32'd0);
    checkOutput("midReset push", {31'd0, fifo_push_data}, 32'd0);
    checkOutput("midReset ch_pop", {28'd0, ch_pop}, 32'd0);
    reset_n = 1'b1;
    // Pointer back at 0: ch0 must win over ch3, then ch3 follows.
    lenCfg[0] = 8'd1; lenCfg[3] = 8'd2;
    pktCnt[0] = 1; pktCnt[3] = 1;
    idxCh[0] = 0; idxCh[3] = 0;
    expectFrame(0, 1, 0);
    expectFrame(3, 2, 5);
    applyStimulus();
    waitIdle(100, "afterReset");

    repeat (2) stepCycle();
    checkOutput("queues empty", 32'(expQ.size() + popQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
